// File: rtl/muldiv_hilo_sequencer.sv
// rtl/muldiv_hilo_sequencer.sv - iterative shift-add multiplier owning the HI/LO pair
// Retires BITS_PER_CYCLE multiplier bits per RUN cycle; HI/LO change only at completion.
module muldiv_hilo_sequencer #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             rd_hilo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(N);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] partial, acc_sum, product;

  // Magnitudes stay WIDTH-bit unsigned so -2^(W-1) is carried exactly.
  always_comb begin
    mag_a = (is_signed & op_a[WIDTH-1]) ? -op_a : op_a;
    mag_b = (is_signed & op_b[WIDTH-1]) ? -op_b : op_b;
  end

  always_comb begin
    partial = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (mplier_q[k]) partial = partial + (mcand_q << k);
    end
    acc_sum = acc_q + partial;
    product = neg_q ? -acc_sum : acc_sum;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          cnt_d    = CNT_INIT;
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          neg_d    = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        cnt_d    = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d      = IDLE;
          {hi_d, lo_d} = product;
          done_d       = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign stall = busy & (start | rd_hilo);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_sequencer.sv
// tb/tb_muldiv_hilo_sequencer.sv - scoreboard bench for muldiv_hilo_sequencer
// Two instances (1 and 4 bits per cycle) exercised in turn against a 64-bit arithmetic model.
module tb_muldiv_hilo_sequencer;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_s   [2];
  logic         start_s [2];
  logic         sgn_s   [2];
  logic [W-1:0] a_s     [2];
  logic [W-1:0] b_s     [2];
  logic         rd_s    [2];
  logic         busy_s  [2];
  logic         stall_s [2];
  logic         done_s  [2];
  logic [W-1:0] hi_s    [2];
  logic [W-1:0] lo_s    [2];

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_dut
    muldiv_hilo_sequencer #(.WIDTH(W), .BITS_PER_CYCLE(gi == 0 ? 1 : 4)) dut (
      .clk      (clk),
      .reset    (rst_s[gi]),
      .start    (start_s[gi]),
      .is_signed(sgn_s[gi]),
      .op_a     (a_s[gi]),
      .op_b     (b_s[gi]),
      .rd_hilo  (rd_s[gi]),
      .busy     (busy_s[gi]),
      .stall    (stall_s[gi]),
      .done     (done_s[gi]),
      .hi       (hi_s[gi]),
      .lo       (lo_s[gi])
    );
  end

  typedef struct {
    int          inst;
    logic [63:0] prod;
  } exp_t;

  exp_t sb_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit drv_err  = 1'b0;

  int          busy_end  [2];
  bit          pend      [2];
  logic [63:0] last_prod [2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nc(input int g);
    return (g == 0) ? 32 : 8;
  endfunction

  task automatic chk(input string name, input int g, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d actual=%h required=%h", name, g, cyc, act, exp);
    end
  endtask

  // Monitor: model busy/done timing from accepted starts, pop expected products on done.
  always @(negedge clk) begin
    bit   mbusy;
    bit   edone;
    exp_t e;
    chk("driver_ok", 0, 64'(drv_err), 64'd0);
    for (int g = 0; g < 2; g++) begin
      if (rst_s[g]) begin
        busy_end[g]  = 0;
        pend[g]      = 1'b0;
        last_prod[g] = '0;
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
          if (sb_q[i].inst == g) sb_q.delete(i);
        end
      end else begin
        mbusy = pend[g] && (cyc < busy_end[g]);
        edone = pend[g] && (cyc == busy_end[g]);
        chk("busy", g, 64'(busy_s[g]), 64'(mbusy));
        chk("stall", g, 64'(stall_s[g]), 64'(mbusy & (start_s[g] | rd_s[g])));
        chk("done", g, 64'(done_s[g]), 64'(edone));
        if (edone) begin
          pend[g] = 1'b0;
          if (sb_q.size() > 0 && sb_q[0].inst == g) begin
            e = sb_q.pop_front();
            chk("product", g, {hi_s[g], lo_s[g]}, e.prod);
            last_prod[g] = e.prod;
          end else begin
            checks++;
            failures++;
            $display("FAIL sb_underflow inst=%0d cyc=%0d actual=empty required=entry", g, cyc);
          end
        end else begin
          chk("hilo_hold", g, {hi_s[g], lo_s[g]}, last_prod[g]);
        end
        if (start_s[g] && !mbusy) begin
          pend[g]     = 1'b1;
          busy_end[g] = cyc + 1 + nc(g);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input int g, input logic [31:0] a, input logic [31:0] b, input bit s, input bit rd);
    exp_t e;
    bit   ok;
    e.inst = g;
    if (s) e.prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    else   e.prod = {32'd0, a} * {32'd0, b};
    sb_q.push_back(e);
    start_s[g] = 1'b1;
    sgn_s[g]   = s;
    a_s[g]     = a;
    b_s[g]     = b;
    rd_s[g]    = rd;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = !stall_s[g];
      @(posedge clk);
      #1;
    end
    if (!ok) drv_err = 1'b1;
    start_s[g] = 1'b0;
    rd_s[g]    = 1'b0;
  endtask

  task automatic read_hilo(input int g);
    bit ok;
    rd_s[g] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = !stall_s[g];
      @(posedge clk);
      #1;
    end
    if (!ok) drv_err = 1'b1;
    rd_s[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = (sb_q.size() == 0) && !busy_s[g];
      @(posedge clk);
      #1;
    end
    if (!ok) drv_err = 1'b1;
  endtask

  task automatic pulse_reset(input int g);
    rst_s[g] = 1'b1;
    @(posedge clk);
    #1;
    rst_s[g] = 1'b0;
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic run_tests(input int g);
    issue(g, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_idle(g);
    issue(g, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 1'b0);
    issue(g, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    wait_idle(g);
    issue(g, 32'd6, 32'd7, 1'b0, 1'b0);
    idle(4);
    read_hilo(g);
    wait_idle(g);
    issue(g, 32'd100, 32'd200, 1'b0, 1'b0);
    issue(g, 32'd2, 32'd3, 1'b0, 1'b0);
    wait_idle(g);
    issue(g, 32'd5, 32'hFFFF_FFF7, 1'b1, 1'b1);
    wait_idle(g);
    issue(g, 32'd123, 32'd456, 1'b0, 1'b0);
    idle(9);
    pulse_reset(g);
    idle(nc(g) + 5);
    issue(g, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0);
    wait_idle(g);
    for (int i = 0; i < 1000; i++) begin
      issue(g, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) begin
        idle($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) read_hilo(g);
      end
    end
    wait_idle(g);
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      rst_s[g]   = 1'b1;
      start_s[g] = 1'b0;
      sgn_s[g]   = 1'b0;
      a_s[g]     = '0;
      b_s[g]     = '0;
      rd_s[g]    = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;
    idle(2);
    for (int g = 0; g < 2; g++) run_tests(g);
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
